// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types, ALU opcodes and forward-select codes
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_SUB   = 4'h1,
      ALU_AND   = 4'h2,
      ALU_OR    = 4'h3,
      ALU_XOR   = 4'h4,
      ALU_NOR   = 4'h5,
      ALU_SLT   = 4'h6,
      ALU_SLTU  = 4'h7,
      ALU_SLL   = 4'h8,
      ALU_SRL   = 4'h9,
      ALU_SRA   = 4'hA,
      ALU_LUI   = 4'hB,
      ALU_PASSA = 4'hC,
      ALU_PASSB = 4'hD,
      ALU_ADDU  = 4'hE,
      ALU_SUBU  = 4'hF
   } aluop_t;

   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_EXM  = 2'd1;
   localparam logic [1:0] FWD_WB   = 2'd2;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - forward source select for one ALU operand
module fwd_unit
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic [REG_W-1:0]  src,
   input  logic [WORD_W-1:0] latched,
   input  logic              exm_reg_write,
   input  logic [REG_W-1:0]  exm_rd,
   input  logic [WORD_W-1:0] exm_result,
   input  logic              wb_reg_write,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [WORD_W-1:0] wb_result,
   output logic [1:0]        sel,
   output logic [WORD_W-1:0] data
);

   // r0 never forwards; the younger EX/MEM result beats MEM/WB
   always_comb begin
      sel  = FWD_NONE;
      data = latched;
      if (src != '0) begin
         if (exm_reg_write && (exm_rd == src)) begin
            sel  = FWD_EXM;
            data = exm_result;
         end else if (wb_reg_write && (wb_rd == src)) begin
            sel  = FWD_WB;
            data = wb_result;
         end
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - EX operand register with forwarding, load-use stall and backpressure
module ex_operand_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              id_valid,
   input  logic [3:0]        id_aluop,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [WORD_W-1:0] id_rs_data,
   input  logic [WORD_W-1:0] id_rt_data,
   input  logic [WORD_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   output logic              stall_id,
   input  logic              exm_reg_write,
   input  logic [REG_W-1:0]  exm_rd,
   input  logic [WORD_W-1:0] exm_result,
   input  logic              wb_reg_write,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [WORD_W-1:0] wb_result,
   input  logic              ex_ready,
   input  logic              flush,
   output logic              ex_valid,
   output logic [WORD_W-1:0] portA,
   output logic [WORD_W-1:0] portB,
   output logic [3:0]        ALUOP,
   output logic [REG_W-1:0]  ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   logic              valid_q;
   aluop_t            aluop_q;
   logic [REG_W-1:0]  rs_q, rt_q, rd_q;
   logic [WORD_W-1:0] rs_data_q, rt_data_q, imm_q;
   logic              use_imm_q, reg_write_q, mem_read_q;

   logic [WORD_W-1:0] fwd_rs_data, fwd_rt_data;
   logic [1:0]        sel_rs, sel_rt;
   logic              hold, haz;

   fwd_unit #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_rs (
      .src(rs_q), .latched(rs_data_q),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .sel(sel_rs), .data(fwd_rs_data)
   );

   fwd_unit #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_rt (
      .src(rt_q), .latched(rt_data_q),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .sel(sel_rt), .data(fwd_rt_data)
   );

   // Operand muxing, pass-through gating and hazard detection
   always_comb begin
      ex_valid     = valid_q;
      ex_rd        = rd_q;
      ex_reg_write = valid_q && reg_write_q;
      ex_mem_read  = valid_q && mem_read_q;
      ALUOP        = aluop_q;
      portA        = fwd_rs_data;
      fwd_a        = sel_rs;
      portB        = use_imm_q ? imm_q : fwd_rt_data;
      fwd_b        = use_imm_q ? FWD_NONE : sel_rt;
      hold         = valid_q && !ex_ready;
      haz          = ex_mem_read && (rd_q != '0) && id_valid &&
                     ((id_rs == rd_q) || (!id_use_imm && (id_rt == rd_q)));
      stall_id     = haz || hold;
   end

   // Stage register: reset > flush > hold (refresh operands) > bubble > load
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q     <= 1'b0;
         aluop_q     <= ALU_ADD;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         use_imm_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (hold) begin
         rs_data_q <= fwd_rs_data;
         rt_data_q <= fwd_rt_data;
      end else if (haz) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         valid_q     <= id_valid;
         aluop_q     <= aluop_t'(id_aluop);
         rs_q        <= id_rs;
         rt_q        <= id_rt;
         rd_q        <= id_rd;
         rs_data_q   <= id_rs_data;
         rt_data_q   <= id_rt_data;
         imm_q       <= id_imm;
         use_imm_q   <= id_use_imm;
         reg_write_q <= id_reg_write;
         mem_read_q  <= id_mem_read;
      end
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed cycle-table bench for ex_operand_stage
module tb_ex_operand_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        id_valid;
   logic [3:0]  id_aluop;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_use_imm, id_reg_write, id_mem_read;
   logic        stall_id;
   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic        ex_ready, flush;
   logic        ex_valid;
   logic [31:0] portA, portB;
   logic [3:0]  ALUOP;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read;
   logic [1:0]  fwd_a, fwd_b;

   always #5 CLK = ~CLK;

   ex_operand_stage #(.WORD_W(32), .REG_W(5)) dut (
      .CLK(CLK), .RST(RST),
      .id_valid(id_valid), .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .stall_id(stall_id),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
      .portA(portA), .portB(portB), .ALUOP(ALUOP), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   // per-cycle inputs: rst v op rs rsd rt rtd imm ui rd rw mr xw xrd xres ww wrd wres rdy fl
   typedef struct {
      logic rst; logic v; logic [3:0] op;
      logic [4:0] rs; logic [31:0] rsd; logic [4:0] rt; logic [31:0] rtd;
      logic [31:0] imm; logic ui; logic [4:0] rd; logic rw; logic mr;
      logic xw; logic [4:0] xrd; logic [31:0] xres;
      logic ww; logic [4:0] wrd; logic [31:0] wres;
      logic rdy; logic fl;
   } in_t;

   // outputs seen that cycle: v a b op rd rw mr fa fb st, dc=1 means operand fields not checked
   typedef struct {
      logic v; logic [31:0] a; logic [31:0] b; logic [3:0] op; logic [4:0] rd;
      logic rw; logic mr; logic [1:0] fa; logic [1:0] fb; logic st; logic dc;
   } exp_t;

   typedef struct { string name; in_t i; exp_t e; } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(input string n, input in_t i, input exp_t e);
      vec_t r;
      r.name = n; r.i = i; r.e = e;
      tbl.push_back(r);
   endfunction

   // Drive one cycle's inputs after the falling edge, then check the settled outputs
   task automatic run(input string n, input in_t i, input exp_t e);
      exp_t a;
      logic bad;
      @(negedge CLK);
      RST = i.rst; id_valid = i.v; id_aluop = i.op; id_rs = i.rs; id_rs_data = i.rsd;
      id_rt = i.rt; id_rt_data = i.rtd; id_imm = i.imm; id_use_imm = i.ui; id_rd = i.rd;
      id_reg_write = i.rw; id_mem_read = i.mr;
      exm_reg_write = i.xw; exm_rd = i.xrd; exm_result = i.xres;
      wb_reg_write = i.ww; wb_rd = i.wrd; wb_result = i.wres;
      ex_ready = i.rdy; flush = i.fl;
      #1;
      a = '{ex_valid, portA, portB, ALUOP, ex_rd, ex_reg_write, ex_mem_read, fwd_a, fwd_b, stall_id, 1'b0};
      bad = (a.v !== e.v) || (a.rw !== e.rw) || (a.mr !== e.mr) || (a.st !== e.st);
      if (!e.dc)
         bad = bad || (a.a !== e.a) || (a.b !== e.b) || (a.op !== e.op) || (a.rd !== e.rd) ||
               (a.fa !== e.fa) || (a.fb !== e.fb);
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s: got v=%b A=%h B=%h op=%h rd=%0d rw=%b mr=%b fa=%0d fb=%0d st=%b, want v=%b A=%h B=%h op=%h rd=%0d rw=%b mr=%b fa=%0d fb=%0d st=%b",
                  n, a.v, a.a, a.b, a.op, a.rd, a.rw, a.mr, a.fa, a.fb, a.st,
                  e.v, e.a, e.b, e.op, e.rd, e.rw, e.mr, e.fa, e.fb, e.st);
      end
   endtask

   in_t  idle, hid;
   exp_t ez;

   initial begin
      idle = '{0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1,0};
      ez   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      RST = 1'b1; id_valid = 1'b0; id_aluop = '0; id_rs = '0; id_rt = '0; id_rd = '0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_use_imm = 1'b0;
      id_reg_write = 1'b0; id_mem_read = 1'b0;
      exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
      ex_ready = 1'b1; flush = 1'b0;
      repeat (2) @(posedge CLK);

      // reset state, then a plain issue with one-cycle latency
      add("reset_state", idle, ez);
      add("basic_issue", '{0,1,0, 1,1, 2,2, 0,0, 3,1,0, 0,0,0, 0,0,0, 1,0}, ez);
      add("basic_out",   idle, '{1, 1, 2, 0, 3, 1, 0, 0, 0, 0, 0});
      // immediate B operand ignores a matching EX/MEM on rt
      add("imm_issue",   '{0,1,1, 4,7, 9,'h55, 'hFFFFFFF0,1, 6,1,0, 0,0,0, 0,0,0, 1,0}, ez);
      add("imm_out",     '{0,0,0, 0,0, 0,0, 0,0, 0,0,0, 1,9,'h99, 0,0,0, 1,0}, '{1, 7, 'hFFFFFFF0, 1, 6, 1, 0, 0, 0, 0, 0});
      // EX/MEM wins over MEM/WB; r0 and exm_rd=0 never forward
      add("fwd_issue",   '{0,1,2, 3,3, 0,'h77, 0,0, 7,1,0, 0,0,0, 0,0,0, 1,0}, ez);
      add("fwd_exm_prio",'{0,1,3, 0,5, 8,8, 0,0, 9,1,0, 1,3,'h10, 1,3,'h20, 1,0}, '{1, 'h10, 'h77, 2, 7, 1, 0, 1, 0, 0, 0});
      add("fwd_r0_wb",   '{0,0,0, 0,0, 0,0, 0,0, 0,0,0, 1,0,'hDEAD, 1,8,'h88, 1,0}, '{1, 5, 'h88, 3, 9, 1, 0, 0, 2, 0, 0});
      // load-use: one stall cycle, bubble, then MEM/WB forward on rt
      add("lu_load",     '{0,1,0, 1,'h100, 0,0, 4,1, 5,1,1, 0,0,0, 0,0,0, 1,0}, ez);
      add("lu_stall",    '{0,1,0, 6,'h60, 5,5, 0,0, 10,1,0, 0,0,0, 0,0,0, 1,0}, '{1, 'h100, 4, 0, 5, 1, 1, 0, 0, 1, 0});
      add("lu_bubble",   '{0,1,0, 6,'h60, 5,5, 0,0, 10,1,0, 0,0,0, 0,0,0, 1,0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      add("lu_fwd",      '{0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 1,5,'hCAFE, 1,0}, '{1, 'h60, 'hCAFE, 0, 10, 1, 0, 0, 2, 0, 0});
      // flush while held
      add("fl_issue",    '{0,1,6, 1,'h11, 2,'h22, 0,0, 15,1,0, 0,0,0, 0,0,0, 1,0}, ez);
      add("fl_hold",     '{0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0}, '{1, 'h11, 'h22, 6, 15, 1, 0, 0, 0, 1, 0});
      add("fl_flush",    '{0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,1}, '{1, 'h11, 'h22, 6, 15, 1, 0, 0, 0, 1, 0});
      add("fl_after",    '{0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      // flush coinciding with a load-use hazard
      add("fh_load",     '{0,1,0, 1,'h200, 0,0, 8,1, 4,1,1, 0,0,0, 0,0,0, 1,0}, ez);
      add("fh_both",     '{0,1,7, 4,'h44, 0,9, 0,0, 2,1,0, 0,0,0, 0,0,0, 1,1}, '{1, 'h200, 8, 0, 4, 1, 1, 0, 0, 1, 0});
      add("fh_after",    '{0,1,7, 4,'h44, 0,9, 0,0, 2,1,0, 0,0,0, 0,0,0, 1,0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      add("fh_replay",   idle, '{1, 'h44, 9, 7, 2, 1, 0, 0, 0, 0, 0});

      foreach (tbl[k]) run(tbl[k].name, tbl[k].i, tbl[k].e);

      // three-cycle hold: MEM/WB value seen only on cycle 1 must survive in portA
      hid = '{0,1,5, 12,'hC, 13,'hD, 0,0, 14,1,0, 0,0,0, 0,0,0, 0,0};
      run("hold_issue", '{0,1,4, 2,1, 3,'h33, 0,0, 11,1,0, 0,0,0, 0,0,0, 1,0}, ez);
      hid.ww = 1; hid.wrd = 2; hid.wres = 'hABCD;
      run("hold_c1", hid, '{1, 'hABCD, 'h33, 4, 11, 1, 0, 2, 0, 1, 0});
      hid.ww = 0; hid.wrd = 0; hid.wres = 0;
      run("hold_c2", hid, '{1, 'hABCD, 'h33, 4, 11, 1, 0, 0, 0, 1, 0});
      hid.xw = 1; hid.xrd = 3; hid.xres = 'h3333;
      run("hold_c3", hid, '{1, 'hABCD, 'h3333, 4, 11, 1, 0, 0, 1, 1, 0});
      hid.xw = 0; hid.xrd = 0; hid.xres = 0; hid.rdy = 1;
      run("hold_release", hid, '{1, 'hABCD, 'h3333, 4, 11, 1, 0, 0, 0, 0, 0});
      run("hold_next", idle, '{1, 'hC, 'hD, 5, 14, 1, 0, 0, 0, 0, 0});

      // reset asserted during a load-use stall clears everything; decode replays
      run("rs_load",    '{0,1,0, 1,'h300, 0,0, 'hC,1, 6,1,1, 0,0,0, 0,0,0, 1,0}, ez);
      run("rs_stall",   '{1,1,2, 6,'h66, 0,0, 0,0, 8,1,0, 0,0,0, 0,0,0, 1,0}, '{1, 'h300, 'hC, 0, 6, 1, 1, 0, 0, 1, 0});
      run("rs_cleared", '{0,1,2, 6,'h66, 0,0, 0,0, 8,1,0, 0,0,0, 0,0,0, 1,0}, ez);
      run("rs_replay",  idle, '{1, 'h66, 0, 2, 8, 1, 0, 0, 0, 0, 0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
